delay_line_meas: RTL and testbench

Measurement sequencer that sits directly upstream and downstream of the delay line. It launches a rising edge into the line and captures the line's tap vector one clock later. The captured thermometer code is converted to a tap count, 2^AVG_LOG2 samples are accumulated, and the averaged-sum result is presented on a valid/ready interface for the top-level output mux.

---
 rtl/delay_line_meas_if.sv | 24 ++
 rtl/delay_line_meas.sv | 156 +++++++++++++++
 tb/tb_delay_line_meas.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/delay_line_meas_if.sv
// Result channel between the delay-line measurement sequencer and the output mux.
// The master presents a held result with valid; the slave accepts it with ready.
interface delay_line_meas_if #(
    parameter int unsigned RES_W = 9
);
    logic             o_valid;
    logic             i_ready;
    logic [RES_W-1:0] o_result;
    logic             o_ovf;

    modport master (
        output o_valid,
        output o_result,
        output o_ovf,
        input  i_ready
    );

    modport slave (
        input  o_valid,
        input  o_result,
        input  o_ovf,
        output i_ready
    );
endinterface

// File: rtl/delay_line_meas.sv
// Delay-line measurement sequencer: launches an edge, captures the tap thermometer
// code, accumulates 2^AVG_LOG2 tap counts and hands the sum out on valid/ready.
module delay_line_meas #(
    parameter int unsigned TAPS     = 32,
    parameter int unsigned CNT_W    = $clog2(TAPS + 1),
    parameter int unsigned AVG_LOG2 = 3,
    parameter int unsigned CLR_CYC  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    output logic              o_launch,
    input  logic [TAPS-1:0]   i_taps,
    output logic              o_busy,
    delay_line_meas_if.master res
);

    localparam int unsigned ACC_W = CNT_W + AVG_LOG2;
    localparam int unsigned IDX_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int unsigned CLR_W = 4;
    localparam int unsigned NSAMP = 1 << AVG_LOG2;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_FIRE  = 3'd2,
        S_WAIT  = 3'd3,
        S_ACC   = 3'd4,
        S_DONE  = 3'd5
    } state_e;

    state_e            state_q, state_d;
    logic [TAPS-1:0]   cap_q, cap_qq;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [CLR_W-1:0]  clr_q, clr_d;
    logic              ovf_q, ovf_d;
    logic              launch_q, launch_d;
    logic              busy_q, busy_d;
    logic              valid_q, valid_d;
    logic [CNT_W-1:0]  count_c;
    logic              last_c;
    logic              clr_end_c;

    // Two-flop capture of the asynchronous tap vector; only cap_qq feeds logic.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_q  <= '0;
            cap_qq <= '0;
        end else begin
            cap_q  <= i_taps;
            cap_qq <= cap_q;
        end
    end

    // Run length of ones from tap 0; anything above the first zero is a bubble.
    always_comb begin
        count_c = CNT_W'(TAPS);
        for (int i = int'(TAPS) - 1; i >= 0; i--) begin
            if (!cap_qq[i]) begin
                count_c = CNT_W'(i);
            end
        end
    end

    assign last_c    = (idx_q == IDX_W'(NSAMP - 1));
    assign clr_end_c = (clr_q == CLR_W'(CLR_CYC - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (i_start) state_d = S_CLEAR;
            S_CLEAR: if (clr_end_c) state_d = S_FIRE;
            S_FIRE:  state_d = S_WAIT;
            S_WAIT:  state_d = S_ACC;
            S_ACC:   state_d = last_c ? S_DONE : S_CLEAR;
            S_DONE:  if (valid_q && res.i_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath updates and registered-output next values, keyed off the FSM.
    always_comb begin
        acc_d    = acc_q;
        idx_d    = idx_q;
        ovf_d    = ovf_q;
        clr_d    = clr_q;
        launch_d = 1'b0;
        busy_d   = 1'b0;
        valid_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    acc_d = '0;
                    idx_d = '0;
                    ovf_d = 1'b0;
                    clr_d = '0;
                end
            end
            S_CLEAR: begin
                clr_d = clr_q + CLR_W'(1);
            end
            S_ACC: begin
                acc_d = acc_q + ACC_W'(count_c);
                ovf_d = ovf_q | (count_c == CNT_W'(TAPS));
                clr_d = '0;
                if (!last_c) begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            default: ;
        endcase

        // Outputs are registered from the next state so they align with the state.
        launch_d = (state_d == S_FIRE) || (state_d == S_WAIT);
        busy_d   = (state_d == S_CLEAR) || (state_d == S_FIRE) ||
                   (state_d == S_WAIT)  || (state_d == S_ACC);
        valid_d  = (state_d == S_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q    <= '0;
            idx_q    <= '0;
            ovf_q    <= 1'b0;
            clr_q    <= '0;
            launch_q <= 1'b0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            idx_q    <= idx_d;
            ovf_q    <= ovf_d;
            clr_q    <= clr_d;
            launch_q <= launch_d;
            busy_q   <= busy_d;
            valid_q  <= valid_d;
        end
    end

    assign o_launch     = launch_q;
    assign o_busy       = busy_q;
    assign res.o_valid  = valid_q;
    assign res.o_result = acc_q;
    assign res.o_ovf    = ovf_q;

endmodule

// File: tb/tb_delay_line_meas.sv
// Directed bench for delay_line_meas with a behavioural delay line that shows the
// programmed tap pattern while the launch edge is high.
module tb_delay_line_meas;

    localparam int unsigned TAPS  = 32;
    localparam int unsigned RES_W = 9;

    logic              clk;
    logic              rst;
    logic              start;
    logic              launch;
    logic [TAPS-1:0]   taps;
    logic              busy;
    logic              ready;
    logic [TAPS-1:0]   pattern;

    int total;
    int passed;
    int launch_cyc;
    int launch_rise;
    logic launch_prev;

    delay_line_meas_if #(.RES_W(RES_W)) res_if ();

    assign res_if.i_ready = ready;
    assign taps = launch ? pattern : '0;

    delay_line_meas dut (
        .clk      (clk),
        .rst      (rst),
        .i_start  (start),
        .o_launch (launch),
        .i_taps   (taps),
        .o_busy   (busy),
        .res      (res_if.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        launch_cyc  = 0;
        launch_rise = 0;
        launch_prev = 1'b0;
    end

    always @(posedge clk) begin
        if (launch === 1'b1) launch_cyc = launch_cyc + 1;
        if (launch === 1'b1 && launch_prev !== 1'b1) launch_rise = launch_rise + 1;
        launch_prev = launch;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Starts a measurement and waits (bounded) for valid; reports cycles from E0.
    task automatic run(input logic [TAPS-1:0] pat, output int cyc, output logic busy_ok);
        pattern = pat;
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        cyc     = 0;
        busy_ok = 1'b1;
        while (res_if.o_valid !== 1'b1 && cyc < 100) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic ack();
        ready = 1'b1;
        @(posedge clk);
        #1 ready = 1'b0;
    endtask

    int   cyc;
    logic busy_ok;
    int   l0, r0;
    logic stable;

    initial begin
        total   = 0;
        passed  = 0;
        rst     = 1'b0;
        start   = 1'b0;
        ready   = 1'b0;
        pattern = '0;

        // Reset asserted mid-cycle
        #3 rst = 1'b1;
        #1;
        chk("rst_launch", 32'(launch), 0);
        chk("rst_busy",   32'(busy), 0);
        chk("rst_valid",  32'(res_if.o_valid), 0);
        chk("rst_result", 32'(res_if.o_result), 0);
        chk("rst_ovf",    32'(res_if.o_ovf), 0);
        #8 rst = 1'b0;

        // Nominal: 13 ones per sample
        l0 = launch_cyc;
        r0 = launch_rise;
        run(32'h0000_1FFF, cyc, busy_ok);
        chk("nom_latency",   32'(cyc), 40);
        chk("nom_busy_run",  32'(busy_ok), 1);
        chk("nom_valid",     32'(res_if.o_valid), 1);
        chk("nom_result",    32'(res_if.o_result), 104);
        chk("nom_ovf",       32'(res_if.o_ovf), 0);
        chk("nom_busy_done", 32'(busy), 0);
        chk("nom_launch_cyc",  32'(launch_cyc - l0), 16);
        chk("nom_launch_rise", 32'(launch_rise - r0), 8);

        // Backpressure with a stray start while the result is held
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (i == 4) start = 1'b1;
            @(posedge clk);
            #1 start = 1'b0;
            if (!(res_if.o_valid === 1'b1 && res_if.o_result === 9'd104 && busy === 1'b0))
                stable = 1'b0;
        end
        chk("bp_stable", 32'(stable), 1);
        ack();
        chk("bp_valid_drop", 32'(res_if.o_valid), 0);
        chk("bp_idle_busy",  32'(busy), 0);
        @(posedge clk);
        #1;
        chk("bp_start_ignored", 32'(busy), 0);

        // Bubble above the first zero is ignored
        run(32'h0000_00EF, cyc, busy_ok);
        chk("bub_latency", 32'(cyc), 40);
        chk("bub_result",  32'(res_if.o_result), 32);
        chk("bub_ovf",     32'(res_if.o_ovf), 0);
        ack();

        // All taps set on every sample
        run(32'hFFFF_FFFF, cyc, busy_ok);
        chk("ovf_result", 32'(res_if.o_result), 256);
        chk("ovf_flag",   32'(res_if.o_ovf), 1);
        ack();

        // Overflow flag cleared by the next measurement
        run(32'h0000_003F, cyc, busy_ok);
        chk("post_ovf_result", 32'(res_if.o_result), 48);
        chk("post_ovf_flag",   32'(res_if.o_ovf), 0);
        ack();

        // Reset in the middle of a measurement
        pattern = 32'h0000_1FFF;
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (20) @(posedge clk);
        chk("mid_busy_before", 32'(busy), 1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_launch", 32'(launch), 0);
        chk("mid_rst_busy",   32'(busy), 0);
        chk("mid_rst_valid",  32'(res_if.o_valid), 0);
        chk("mid_rst_result", 32'(res_if.o_result), 0);
        chk("mid_rst_ovf",    32'(res_if.o_ovf), 0);
        #3 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("mid_needs_start", 32'(busy), 0);
        run(32'h0000_1FFF, cyc, busy_ok);
        chk("mid_rerun_latency", 32'(cyc), 40);
        chk("mid_rerun_result",  32'(res_if.o_result), 104);
        ack();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
